// File: rtl/sargantana_icache_refill_if.sv
// sargantana_icache_refill_if: request, L2 and response signals of the icache refill unit
interface sargantana_icache_refill_if #(
    parameter int PADDR_W = 40,
    parameter int BEAT_W  = 128,
    parameter int N_BEATS = 2,
    parameter int WAY_W   = 2
);
    localparam int IDX_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    logic                      req_valid_i;
    logic [PADDR_W-1:0]        req_paddr_i;
    logic [WAY_W-1:0]          req_way_i;
    logic                      req_ready_o;
    logic                      kill_i;
    logic                      l2_req_valid_o;
    logic [PADDR_W-1:0]        l2_req_paddr_o;
    logic                      l2_req_ready_i;
    logic                      l2_beat_valid_i;
    logic [BEAT_W-1:0]         l2_beat_data_i;
    logic [IDX_W-1:0]          l2_beat_idx_i;
    logic                      l2_inv_valid_i;
    logic [PADDR_W-1:0]        l2_inv_paddr_i;
    logic                      l2_inv_ready_o;
    logic                      resp_valid_o;
    logic [BEAT_W*N_BEATS-1:0] resp_data_o;
    logic [WAY_W-1:0]          resp_way_o;
    logic                      resp_inv_valid_o;
    logic [PADDR_W-1:0]        resp_inv_paddr_o;
    logic                      busy_o;

    modport master (
        output req_valid_i, req_paddr_i, req_way_i, kill_i, l2_req_ready_i,
               l2_beat_valid_i, l2_beat_data_i, l2_beat_idx_i, l2_inv_valid_i, l2_inv_paddr_i,
        input  req_ready_o, l2_req_valid_o, l2_req_paddr_o, l2_inv_ready_o, resp_valid_o,
               resp_data_o, resp_way_o, resp_inv_valid_o, resp_inv_paddr_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_paddr_i, req_way_i, kill_i, l2_req_ready_i,
               l2_beat_valid_i, l2_beat_data_i, l2_beat_idx_i, l2_inv_valid_i, l2_inv_paddr_i,
        output req_ready_o, l2_req_valid_o, l2_req_paddr_o, l2_inv_ready_o, resp_valid_o,
               resp_data_o, resp_way_o, resp_inv_valid_o, resp_inv_paddr_o, busy_o
    );
endinterface

// File: rtl/sargantana_icache_refill.sv
// sargantana_icache_refill: fetches a cache line from L2 beat by beat and forwards L2 invalidations
module sargantana_icache_refill #(
    parameter int PADDR_W = 40,
    parameter int BEAT_W  = 128,
    parameter int N_BEATS = 2,
    parameter int WAY_W   = 2
) (
    input logic clk_i,
    input logic rst_i,
    sargantana_icache_refill_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SEND, WAIT, DELIVER, DRAIN} state_t;

    state_t                    state_q;
    logic [PADDR_W-1:0]        paddr_q;
    logic [WAY_W-1:0]          way_q;
    logic [N_BEATS-1:0]        mask_q;
    logic [N_BEATS-1:0]        mask_d;
    logic [BEAT_W*N_BEATS-1:0] line_q;
    logic                      inv_q;
    logic [PADDR_W-1:0]        inv_paddr_q;
    logic                      accept;
    logic                      beat_hit;
    logic                      mask_full;
    logic                      resp_fire;
    logic                      inv_take;
    logic                      inv_hold;
    logic                      inv_emit;
    logic [PADDR_W-1:0]        inv_src;

    assign accept    = bus.req_valid_i && bus.req_ready_o;
    assign beat_hit  = bus.l2_beat_valid_i && (state_q == WAIT || state_q == DRAIN);
    assign mask_d    = mask_q | (beat_hit ? (N_BEATS'(1) << bus.l2_beat_idx_i) : '0);
    assign mask_full = &mask_d;
    assign resp_fire = (state_q == DELIVER) && !bus.kill_i;

    // An invalidation for the line being filled waits until the fill has been delivered
    assign inv_src   = inv_q ? inv_paddr_q : bus.l2_inv_paddr_i;
    assign inv_take  = bus.l2_inv_valid_i && bus.l2_inv_ready_o;
    assign inv_hold  = (state_q == WAIT || state_q == DELIVER) &&
                       (inv_src[PADDR_W-1:5] == paddr_q[PADDR_W-1:5]);
    assign inv_emit  = !rst_i && !resp_fire && !inv_hold &&
                       (inv_q || (inv_take && state_q != DELIVER));

    assign bus.req_ready_o      = !rst_i && (state_q == IDLE) && !bus.kill_i;
    // A kill coinciding with L2 acceptance keeps valid up so the handshake completes
    assign bus.l2_req_valid_o   = (state_q == SEND) && (!bus.kill_i || bus.l2_req_ready_i);
    assign bus.l2_req_paddr_o   = paddr_q;
    assign bus.l2_inv_ready_o   = !rst_i && !inv_q;
    assign bus.resp_valid_o     = resp_fire;
    assign bus.resp_data_o      = line_q;
    assign bus.resp_way_o       = way_q;
    assign bus.resp_inv_valid_o = inv_emit;
    assign bus.resp_inv_paddr_o = inv_emit ? inv_src : '0;
    assign bus.busy_o           = state_q != IDLE;

    // Fill sequencing: capture request, issue to L2, assemble beats, deliver or drain
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            paddr_q <= '0;
            way_q   <= '0;
            mask_q  <= '0;
            line_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    paddr_q <= bus.req_paddr_i & ~PADDR_W'(31);
                    way_q   <= bus.req_way_i;
                    mask_q  <= '0;
                    state_q <= SEND;
                end
                SEND: begin
                    if (bus.kill_i) state_q <= bus.l2_req_ready_i ? DRAIN : IDLE;
                    else if (bus.l2_req_ready_i) state_q <= WAIT;
                end
                WAIT: begin
                    mask_q <= mask_d;
                    if (beat_hit) line_q[int'(bus.l2_beat_idx_i)*BEAT_W +: BEAT_W] <= bus.l2_beat_data_i;
                    if (mask_full) state_q <= bus.kill_i ? IDLE : DELIVER;
                    else if (bus.kill_i) state_q <= DRAIN;
                end
                DRAIN: begin
                    mask_q <= mask_d;
                    if (mask_full) state_q <= IDLE;
                end
                DELIVER: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // One-entry invalidation buffer, bypassed when it can be emitted on arrival
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inv_q       <= 1'b0;
            inv_paddr_q <= '0;
        end else if (inv_emit) begin
            inv_q <= 1'b0;
        end else if (inv_take) begin
            inv_q       <= 1'b1;
            inv_paddr_q <= bus.l2_inv_paddr_i;
        end
    end
endmodule

// File: tb/tb_sargantana_icache_refill.sv
// tb_sargantana_icache_refill: directed and randomized fills checked against a line-slot model
module tb_sargantana_icache_refill;
    logic clk = 1'b0;
    logic rst;
    int   pass_cnt = 0;
    int   fail_cnt = 0;
    int   total = 0;

    always #5 clk = ~clk;

    sargantana_icache_refill_if #(.PADDR_W(40), .BEAT_W(128), .N_BEATS(2), .WAY_W(2)) bus ();
    sargantana_icache_refill #(.PADDR_W(40), .BEAT_W(128), .N_BEATS(2), .WAY_W(2)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        bus.req_valid_i = 0; bus.req_paddr_i = '0; bus.req_way_i = '0; bus.kill_i = 0;
        bus.l2_req_ready_i = 0; bus.l2_beat_valid_i = 0; bus.l2_beat_data_i = '0;
        bus.l2_beat_idx_i = '0; bus.l2_inv_valid_i = 0; bus.l2_inv_paddr_i = '0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        idle_in();
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // kill: 0 none, 1 in WAIT after first beat, 2 in DELIVER
    // inv: 0 none, 1 at DELIVER, 2 same line during WAIT, 3 other line during WAIT
    task automatic fill(input logic [39:0] pa, input logic [1:0] wy, input int rw, input int first,
                        input int gap, input bit dup, input int kill, input int inv,
                        input logic [127:0] d0, input logic [127:0] d1, input logic [127:0] dd,
                        input string tag);
        logic [127:0] slot [2];
        logic [39:0]  la;
        logic [39:0]  ia;
        bit           pend;
        int           second;
        la = pa & ~40'h1f;
        ia = '0;
        pend = 0;
        second = 1 - first;
        bus.req_valid_i = 1; bus.req_paddr_i = pa; bus.req_way_i = wy;
        smp(); chk({tag, ".req_ready"}, 256'(bus.req_ready_o), 1);
        adv();
        for (int w = 0; w <= rw; w++) begin
            bus.l2_req_ready_i = (w == rw);
            smp();
            chk({tag, ".l2_valid"}, 256'(bus.l2_req_valid_o), 1);
            chk({tag, ".l2_paddr"}, 256'(bus.l2_req_paddr_o), 256'(la));
            adv();
        end
        bus.l2_beat_valid_i = 1; bus.l2_beat_idx_i = 1'(first);
        bus.l2_beat_data_i = first ? d1 : d0;
        slot[first] = bus.l2_beat_data_i;
        if (inv == 2) begin bus.l2_inv_valid_i = 1; bus.l2_inv_paddr_i = la | 40'h8; ia = la | 40'h8; pend = 1; end
        if (inv == 3) begin bus.l2_inv_valid_i = 1; bus.l2_inv_paddr_i = la ^ 40'h100; end
        smp();
        chk({tag, ".resp_b0"}, 256'(bus.resp_valid_o), 0);
        if (inv == 2) chk({tag, ".inv_held"}, 256'(bus.resp_inv_valid_o), 0);
        if (inv == 3) begin
            chk({tag, ".inv_bypass"}, 256'(bus.resp_inv_valid_o), 1);
            chk({tag, ".inv_bypass_pa"}, 256'(bus.resp_inv_paddr_o), 256'(la ^ 40'h100));
        end
        adv();
        if (dup) begin
            bus.l2_beat_valid_i = 1; bus.l2_beat_idx_i = 1'(first); bus.l2_beat_data_i = dd;
            slot[first] = dd;
            smp(); chk({tag, ".resp_dup"}, 256'(bus.resp_valid_o), 0);
            if (pend) chk({tag, ".inv_held_dup"}, 256'(bus.resp_inv_valid_o), 0);
            adv();
        end
        if (kill == 1) begin
            bus.kill_i = 1;
            smp(); chk({tag, ".resp_kill"}, 256'(bus.resp_valid_o), 0);
            chk({tag, ".busy_kill"}, 256'(bus.busy_o), 1);
            adv();
        end
        for (int g = 0; g < gap; g++) begin
            smp(); chk({tag, ".resp_gap"}, 256'(bus.resp_valid_o), 0);
            chk({tag, ".busy_gap"}, 256'(bus.busy_o), 1);
            adv();
        end
        bus.l2_beat_valid_i = 1; bus.l2_beat_idx_i = 1'(second);
        bus.l2_beat_data_i = second ? d1 : d0;
        slot[second] = bus.l2_beat_data_i;
        smp(); chk({tag, ".resp_b1"}, 256'(bus.resp_valid_o), 0);
        adv();
        if (kill == 2) bus.kill_i = 1;
        if (inv == 1) begin bus.l2_inv_valid_i = 1; bus.l2_inv_paddr_i = la; ia = la; pend = 1; end
        smp();
        if (kill != 0) chk({tag, ".resp_suppr"}, 256'(bus.resp_valid_o), 0);
        else begin
            chk({tag, ".resp_valid"}, 256'(bus.resp_valid_o), 1);
            chk({tag, ".resp_data"}, bus.resp_data_o, {slot[1], slot[0]});
            chk({tag, ".resp_way"}, 256'(bus.resp_way_o), 256'(wy));
        end
        if (pend) chk({tag, ".inv_vs_resp"}, 256'(bus.resp_inv_valid_o), 0);
        if (inv == 1) chk({tag, ".inv_ready_dlv"}, 256'(bus.l2_inv_ready_o), 1);
        adv();
        smp();
        chk({tag, ".resp_pulse"}, 256'(bus.resp_valid_o), 0);
        chk({tag, ".busy_end"}, 256'(bus.busy_o), 0);
        chk({tag, ".ready_end"}, 256'(bus.req_ready_o), 1);
        if (pend) begin
            chk({tag, ".inv_after"}, 256'(bus.resp_inv_valid_o), 1);
            chk({tag, ".inv_pa"}, 256'(bus.resp_inv_paddr_o), 256'(ia));
            chk({tag, ".inv_full"}, 256'(bus.l2_inv_ready_o), 0);
            adv();
            smp();
            chk({tag, ".inv_clear"}, 256'(bus.resp_inv_valid_o), 0);
            chk({tag, ".inv_ready_again"}, 256'(bus.l2_inv_ready_o), 1);
        end
        adv();
    endtask

    initial begin
        logic [127:0] a;
        logic [127:0] b;
        logic [63:0]  r;
        int           kill;
        a = {32{4'hA}};
        b = {32{4'hB}};
        idle_in();
        rst = 1;
        smp();
        chk("rst.busy", 256'(bus.busy_o), 0);
        chk("rst.req_ready", 256'(bus.req_ready_o), 0);
        chk("rst.inv_ready", 256'(bus.l2_inv_ready_o), 0);
        chk("rst.data", bus.resp_data_o, 0);
        chk("rst.l2_paddr", 256'(bus.l2_req_paddr_o), 0);
        adv();
        rst = 0;
        smp();
        chk("post_rst.req_ready", 256'(bus.req_ready_o), 1);
        chk("post_rst.inv_ready", 256'(bus.l2_inv_ready_o), 1);
        bus.kill_i = 1;
        smp();
        chk("idle_kill.req_ready", 256'(bus.req_ready_o), 0);
        adv();

        fill(40'h80001234, 2'd2, 0, 0, 0, 0, 0, 0, a, b, '0, "basic");
        fill(40'h80001234, 2'd1, 1, 1, 3, 0, 0, 0, a, b, '0, "reorder");
        fill(40'h00abcdef, 2'd3, 0, 0, 1, 0, 1, 0, a, b, '0, "kill_wait");
        fill(40'h80001234, 2'd0, 0, 0, 0, 0, 0, 1, rnd128(), rnd128(), '0, "inv_dlv");
        fill(40'h80001200, 2'd2, 2, 1, 0, 1, 0, 2, rnd128(), rnd128(), rnd128(), "inv_match");
        fill(40'h12345678, 2'd1, 0, 0, 2, 1, 2, 0, rnd128(), rnd128(), rnd128(), "kill_dlv");

        bus.l2_inv_valid_i = 1; bus.l2_inv_paddr_i = 40'h5500000040;
        smp();
        chk("inv_idle.valid", 256'(bus.resp_inv_valid_o), 1);
        chk("inv_idle.pa", 256'(bus.resp_inv_paddr_o), 256'(40'h5500000040));
        adv();
        smp();
        chk("inv_idle.once", 256'(bus.resp_inv_valid_o), 0);

        bus.req_valid_i = 1; bus.req_paddr_i = 40'h40;
        adv();
        bus.kill_i = 1;
        smp();
        chk("kill_send.l2_valid", 256'(bus.l2_req_valid_o), 0);
        adv();
        smp();
        chk("kill_send.busy", 256'(bus.busy_o), 0);
        chk("kill_send.ready", 256'(bus.req_ready_o), 1);

        bus.req_valid_i = 1; bus.req_paddr_i = 40'h80;
        adv();
        bus.kill_i = 1; bus.l2_req_ready_i = 1;
        smp();
        chk("kill_acc.l2_valid", 256'(bus.l2_req_valid_o), 1);
        adv();
        bus.l2_beat_valid_i = 1; bus.l2_beat_idx_i = 1'b0;
        smp();
        chk("kill_acc.busy", 256'(bus.busy_o), 1);
        adv();
        bus.l2_beat_valid_i = 1; bus.l2_beat_idx_i = 1'b1;
        smp();
        chk("kill_acc.resp", 256'(bus.resp_valid_o), 0);
        adv();
        smp();
        chk("kill_acc.resp_end", 256'(bus.resp_valid_o), 0);
        chk("kill_acc.ready", 256'(bus.req_ready_o), 1);

        bus.req_valid_i = 1; bus.req_paddr_i = 40'h80001234; bus.req_way_i = 2'd3;
        adv();
        bus.l2_req_ready_i = 1;
        adv();
        bus.l2_beat_valid_i = 1; bus.l2_beat_idx_i = 1'b0; bus.l2_beat_data_i = a;
        adv();
        #2 rst = 1;
        #1;
        chk("rst_mid.busy", 256'(bus.busy_o), 0);
        chk("rst_mid.data", bus.resp_data_o, 0);
        chk("rst_mid.l2_paddr", 256'(bus.l2_req_paddr_o), 0);
        chk("rst_mid.inv_ready", 256'(bus.l2_inv_ready_o), 0);
        chk("rst_mid.req_ready", 256'(bus.req_ready_o), 0);
        adv();
        rst = 0;
        bus.l2_beat_valid_i = 1; bus.l2_beat_idx_i = 1'b1; bus.l2_beat_data_i = b;
        smp();
        chk("stray.busy", 256'(bus.busy_o), 0);
        adv();
        smp();
        chk("stray.resp", 256'(bus.resp_valid_o), 0);
        chk("stray.ready", 256'(bus.req_ready_o), 1);
        adv();
        fill(40'h80001234, 2'd2, 0, 0, 0, 0, 0, 0, a, b, '0, "after_rst");

        for (int i = 0; i < 24; i++) begin
            r = {$urandom, $urandom};
            kill = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            fill(r[39:0], 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), kill,
                 (kill != 0) ? 0 : int'($urandom_range(0, 3)), rnd128(), rnd128(), rnd128(), "rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
